// File: rtl/prio_arbiter_pkg.sv
// Shared types and helpers for the two-queue priority arbiter.
package prio_arbiter_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_HP   = 2'd1,
    GNT_NP   = 2'd2
  } grant_e;

  // Width of a counter that must hold values 0..burst inclusive.
  function automatic int burst_w(int burst);
    return $clog2(burst + 1);
  endfunction

endpackage

// File: rtl/prio_arbiter_if.sv
// HP/NP input streams and the merged output channel of the arbiter.
interface prio_arbiter_if #(
  parameter int DW = 33
);
  logic [DW-1:0] hp_data;
  logic          hp_vld;
  logic          hp_rdy;
  logic [DW-1:0] np_data;
  logic          np_vld;
  logic          np_rdy;
  logic [DW-1:0] data_out;
  logic          vld_o;
  logic          rdy_i;
  logic          forced_o;

  modport master (
    output hp_data, hp_vld, np_data, np_vld, rdy_i,
    input  hp_rdy, np_rdy, data_out, vld_o, forced_o
  );

  modport slave (
    input  hp_data, hp_vld, np_data, np_vld, rdy_i,
    output hp_rdy, np_rdy, data_out, vld_o, forced_o
  );
endinterface

// File: rtl/prio_arbiter_out_reg.sv
// Single-entry valid/ready output register; reloads whenever empty or being drained.
module out_reg #(
  parameter int DW = 33
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  output logic          load_en,
  output logic [DW-1:0] data,
  output logic          vld
);

  assign load_en = !vld | rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
      vld  <= 1'b0;
    end else if (load_en) begin
      vld <= in_vld;
      if (in_vld) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/prio_arbiter.sv
// Merges HP and NP streams onto one registered output; HP wins unless NP has
// waited through HP_BURST consecutive HP grants.
module prio_arbiter
  import prio_arbiter_pkg::*;
#(
  parameter int DW       = 33,
  parameter int HP_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  prio_arbiter_if.slave bus
);

  localparam int            CW      = burst_w(HP_BURST);
  localparam logic [CW-1:0] CNT_MAX = CW'(HP_BURST);

  grant_e        grant;
  logic          load_en;
  logic          load_ok;
  logic          force_np;
  logic          load_vld;
  logic [DW-1:0] load_data;
  logic [DW-1:0] data_q;
  logic          vld_q;
  logic [CW-1:0] cnt;
  logic          forced_q;

  // Reset gates the grant so neither queue sees a handshake while held in reset.
  assign load_ok  = load_en & rst;
  assign force_np = bus.np_vld & (cnt == CNT_MAX);

  always_comb begin
    grant = GNT_NONE;
    if (load_ok) begin
      if (force_np) begin
        grant = GNT_NP;
      end else if (bus.hp_vld) begin
        grant = GNT_HP;
      end else if (bus.np_vld) begin
        grant = GNT_NP;
      end
    end
  end

  assign bus.hp_rdy = (grant == GNT_HP);
  assign bus.np_rdy = (grant == GNT_NP);
  assign load_vld   = (grant != GNT_NONE);
  assign load_data  = (grant == GNT_NP) ? bus.np_data : bus.hp_data;

  out_reg #(.DW(DW)) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .rdy     (bus.rdy_i),
    .in_vld  (load_vld),
    .in_data (load_data),
    .load_en (load_en),
    .data    (data_q),
    .vld     (vld_q)
  );

  // Counts HP grants that NP sat through; only grant events move it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      case (grant)
        GNT_HP: begin
          if (!bus.np_vld) begin
            cnt <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
          end
        end
        GNT_NP:  cnt <= '0;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      forced_q <= 1'b0;
    end else begin
      forced_q <= load_en & force_np;
    end
  end

  assign bus.data_out = data_q;
  assign bus.vld_o    = vld_q;
  assign bus.forced_o = forced_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed bench for prio_arbiter: vector table on a HP_BURST=4 instance, plus
// alternation on a HP_BURST=1 instance and a mid-stream reset sequence.
module tb_prio_arbiter;

  localparam int DW = 33;

  logic clk;
  logic rst;

  prio_arbiter_if #(.DW(DW)) bus_a ();
  prio_arbiter_if #(.DW(DW)) bus_b ();

  prio_arbiter #(.DW(DW), .HP_BURST(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  prio_arbiter #(.DW(DW), .HP_BURST(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          hp_vld;
    logic [DW-1:0] hp_data;
    logic          np_vld;
    logic [DW-1:0] np_data;
    logic          rdy;
    logic          e_hp_rdy;
    logic          e_np_rdy;
    logic          e_vld;
    logic [DW-1:0] e_data;
    logic          e_forced;
    int            e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [DW-1:0] hw(int k);
    return 33'h1_0000_0000 | 33'(k);
  endfunction

  function automatic logic [DW-1:0] nw(int k);
    return 33'(k);
  endfunction

  function automatic void add(logic hv, logic [DW-1:0] hd, logic nv, logic [DW-1:0] nd,
                              logic rd, logic ehr, logic enr, logic ev,
                              logic [DW-1:0] ed, logic ef, int ec);
    vec_t v;
    v.hp_vld = hv;  v.hp_data = hd;  v.np_vld = nv;  v.np_data = nd;  v.rdy = rd;
    v.e_hp_rdy = ehr; v.e_np_rdy = enr; v.e_vld = ev; v.e_data = ed;
    v.e_forced = ef;  v.e_cnt = ec;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_a(logic hv, logic [DW-1:0] hd, logic nv, logic [DW-1:0] nd, logic rd);
    bus_a.hp_vld = hv; bus_a.hp_data = hd;
    bus_a.np_vld = nv; bus_a.np_data = nd;
    bus_a.rdy_i  = rd;
  endtask

  initial begin
    logic nf;
    bus_a.hp_vld = 1'b0; bus_a.hp_data = '0; bus_a.np_vld = 1'b0; bus_a.np_data = '0;
    bus_a.rdy_i  = 1'b1;
    bus_b.hp_vld = 1'b0; bus_b.hp_data = '0; bus_b.np_vld = 1'b0; bus_b.np_data = '0;
    bus_b.rdy_i  = 1'b1;

    // HP only, back-to-back
    for (int k = 1; k <= 6; k++) add(1, hw(k), 0, '0, 1, 1, 0, 1, hw(k), 0, 0);
    add(0, '0, 0, '0, 1, 0, 0, 0, hw(6), 0, 0);
    // NP only
    for (int k = 0; k < 4; k++) add(0, '0, 1, nw(8'hA0 + k), 1, 0, 1, 1, nw(8'hA0 + k), 0, 0);
    add(0, '0, 0, '0, 1, 0, 0, 0, nw(8'hA3), 0, 0);
    // Both valid: HP x4 then forced NP, twice
    for (int k = 0; k < 10; k++) begin
      nf = (k == 4) || (k == 9);
      add(1, hw(8'h10 + k), 1, nw(8'hB0 + k), 1, !nf, nf, 1,
          nf ? nw(8'hB0 + k) : hw(8'h10 + k), nf, nf ? 0 : (k % 5) + 1);
    end
    // Stall mid-burst: cnt frozen at 2, word held, no word lost on release
    add(1, hw(8'h20), 1, nw(8'hC0), 1, 1, 0, 1, hw(8'h20), 0, 1);
    add(1, hw(8'h21), 1, nw(8'hC0), 1, 1, 0, 1, hw(8'h21), 0, 2);
    for (int k = 0; k < 5; k++) add(1, hw(8'h22), 1, nw(8'hC0), 0, 0, 0, 1, hw(8'h21), 0, 2);
    add(1, hw(8'h22), 1, nw(8'hC0), 1, 1, 0, 1, hw(8'h22), 0, 3);
    add(1, hw(8'h23), 1, nw(8'hC0), 1, 1, 0, 1, hw(8'h23), 0, 4);
    add(1, hw(8'h24), 1, nw(8'hC0), 1, 0, 1, 1, nw(8'hC0), 1, 0);
    // NP withdrawn at cnt == HP_BURST with no grant: cnt holds, next NP is forced
    for (int k = 0; k < 4; k++) add(1, hw(8'h30 + k), 1, nw(8'hD0), 1, 1, 0, 1, hw(8'h30 + k), 0, k + 1);
    add(0, '0, 0, '0, 1, 0, 0, 0, hw(8'h33), 0, 4);
    add(1, hw(8'h34), 1, nw(8'hD0), 1, 0, 1, 1, nw(8'hD0), 1, 0);
    // HP grant with NP absent clears a saturated counter
    for (int k = 0; k < 4; k++) add(1, hw(8'h40 + k), 1, nw(8'hE0), 1, 1, 0, 1, hw(8'h40 + k), 0, k + 1);
    add(1, hw(8'h44), 0, '0, 1, 1, 0, 1, hw(8'h44), 0, 0);
    add(1, hw(8'h45), 1, nw(8'hE0), 1, 1, 0, 1, hw(8'h45), 0, 1);
    add(0, '0, 0, '0, 1, 0, 0, 0, hw(8'h45), 0, 1);

    // Reset held with HP requesting: no handshake, outputs cleared
    rst = 1'b0;
    bus_a.hp_vld = 1'b1; bus_a.hp_data = hw(8'h99);
    repeat (2) @(posedge clk);
    #1;
    check("rst hp_rdy", 64'(bus_a.hp_rdy), 64'(0));
    check("rst vld_o", 64'(bus_a.vld_o), 64'(0));
    check("rst data_out", 64'(bus_a.data_out), 64'(0));
    check("rst forced_o", 64'(bus_a.forced_o), 64'(0));
    check("rst cnt", 64'(dut_a.cnt), 64'(0));
    @(negedge clk);
    bus_a.hp_vld = 1'b0;
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive_a(vecs[i].hp_vld, vecs[i].hp_data, vecs[i].np_vld, vecs[i].np_data, vecs[i].rdy);
      #1;
      check($sformatf("v%0d hp_rdy", i), 64'(bus_a.hp_rdy), 64'(vecs[i].e_hp_rdy));
      check($sformatf("v%0d np_rdy", i), 64'(bus_a.np_rdy), 64'(vecs[i].e_np_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d vld_o", i), 64'(bus_a.vld_o), 64'(vecs[i].e_vld));
      check($sformatf("v%0d data_out", i), 64'(bus_a.data_out), 64'(vecs[i].e_data));
      check($sformatf("v%0d forced_o", i), 64'(bus_a.forced_o), 64'(vecs[i].e_forced));
      check($sformatf("v%0d cnt", i), 64'(dut_a.cnt), 64'(vecs[i].e_cnt));
    end

    // HP_BURST = 1: strict alternation with both queues valid
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus_b.hp_vld = 1'b1; bus_b.hp_data = hw(8'h50 + k);
      bus_b.np_vld = 1'b1; bus_b.np_data = nw(8'h50 + k);
      #1;
      check($sformatf("alt%0d hp_rdy", k), 64'(bus_b.hp_rdy), 64'(k % 2 == 0));
      check($sformatf("alt%0d np_rdy", k), 64'(bus_b.np_rdy), 64'(k % 2 == 1));
      @(posedge clk);
      #1;
      check($sformatf("alt%0d data_out", k), 64'(bus_b.data_out),
            64'((k % 2 == 0) ? hw(8'h50 + k) : nw(8'h50 + k)));
      check($sformatf("alt%0d forced_o", k), 64'(bus_b.forced_o), 64'(k % 2 == 1));
    end
    @(negedge clk);
    bus_b.hp_vld = 1'b0; bus_b.np_vld = 1'b0;

    // Mid-stream reset right after a forced NP load (cnt starts at 1 here)
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_a(1, hw(8'h60), 1, nw(8'h60), 1);
    end
    @(posedge clk);
    #1;
    check("pre-rst forced_o", 64'(bus_a.forced_o), 64'(1));
    check("pre-rst data_out", 64'(bus_a.data_out), 64'(nw(8'h60)));
    #1;
    rst = 1'b0;
    #1;
    check("mid-rst vld_o", 64'(bus_a.vld_o), 64'(0));
    check("mid-rst data_out", 64'(bus_a.data_out), 64'(0));
    check("mid-rst forced_o", 64'(bus_a.forced_o), 64'(0));
    check("mid-rst cnt", 64'(dut_a.cnt), 64'(0));
    check("mid-rst hp_rdy", 64'(bus_a.hp_rdy), 64'(0));
    check("mid-rst np_rdy", 64'(bus_a.np_rdy), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    drive_a(1, hw(8'h61), 1, nw(8'h61), 1);
    #1;
    check("post-rst hp_rdy", 64'(bus_a.hp_rdy), 64'(1));
    check("post-rst np_rdy", 64'(bus_a.np_rdy), 64'(0));
    @(posedge clk);
    #1;
    check("post-rst vld_o", 64'(bus_a.vld_o), 64'(1));
    check("post-rst data_out", 64'(bus_a.data_out), 64'(hw(8'h61)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_arbiter.md
# prio_arbiter

Two-queue output scheduler for the priority FIFO path. It takes a high-priority (HP) and a normal-priority (NP) valid/ready stream, one per queue, and merges them onto a single registered output channel. HP wins by default. A bounded-burst counter forces one NP grant after HP_BURST consecutive HP grants while NP is waiting, so NP traffic cannot starve. It sits between the HP/NP queue outputs and the downstream consumer.

## Interface
- DW, 33, data word width (bit DW-1 is the priority tag and is carried through unchanged)
- HP_BURST, 4, maximum consecutive HP grants while NP is pending; legal range 1..255
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- hp_data  in  DW  HP queue head
- hp_vld  in  1  HP head valid
- hp_rdy  out  1  HP head consumed this cycle
- np_data  in  DW  NP queue head
- np_vld  in  1  NP head valid
- np_rdy  out  1  NP head consumed this cycle
- data_out  out  DW  registered output word
- vld_o  out  1  data_out valid
- rdy_i  in  1  downstream ready
- forced_o  out  1  one-cycle pulse, registered: previous grant was an anti-starvation NP grant

## Operation
- The output stage is one register (data_out, vld_o).
  - load_en = !vld_o | rdy_i.
  - Transfer on the output occurs when vld_o & rdy_i.
- Grant decision is evaluated only when load_en = 1. Otherwise grant = NONE, and hp_rdy = np_rdy = 0.
  - force = np_vld & (cnt == HP_BURST).
  - grant = NP if force.
  - Else grant = HP if hp_vld.
  - Else grant = NP if np_vld.
  - Else grant = NONE.
- hp_rdy = load_en & (grant == HP); np_rdy = load_en & (grant == NP). Each is a combinational function of the vld inputs and rdy_i.
- On grant HP or NP: data_out <= granted data; vld_o <= 1.
- On load_en with grant NONE: vld_o <= 0; data_out holds.
- Burst counter cnt, width $clog2(HP_BURST+1), updates on grant events only:
  - HP grant with np_vld = 1: cnt <= cnt + 1, saturating at HP_BURST.
  - HP grant with np_vld = 0: cnt <= 0.
  - NP grant (forced or not): cnt <= 0.
  - NONE, or load_en = 0: cnt holds.
- forced_o <= load_en & force; otherwise 0.
- An NP request withdrawn while cnt == HP_BURST leaves cnt at HP_BURST. The next HP grant with np_vld = 0 clears it.

## Timing
- Reset (asynchronous assert, synchronous deassert by system): vld_o = 0, data_out = 0, cnt = 0, forced_o = 0. hp_rdy and np_rdy are 0 while held in reset.
- Latency: input handshake in cycle N gives vld_o = 1 with that word in cycle N+1.
- Throughput: one word per cycle while rdy_i stays 1.
- Backpressure: with vld_o = 1 and rdy_i = 0:
  - data_out is stable.
  - hp_rdy = np_rdy = 0.
  - cnt is frozen.
- HP and NP valid in the same cycle: exactly one rdy is asserted, never both.
- Worst-case NP wait once it is valid with rdy_i held at 1: HP_BURST+1 grant cycles.
- Reset asserted mid-transfer: the registered word is discarded and vld_o drops immediately. No partial state survives.

## Structure
- Package prio_arbiter_pkg holds:
  - typedef enum logic[1:0] grant_e {GNT_NONE, GNT_HP, GNT_NP}
  - function burst_w(int) returning the cnt width.
- Sub-module out_reg (DW-wide valid/ready pipeline register with load_en) is natural and reusable. The grant logic and counter stay in prio_arbiter.

## Test plan
- HP_BURST = 4, rdy_i = 1, np_vld = 0, HP words 0x1_0000_0001..0x1_0000_0006 → six HP outputs back-to-back, forced_o never 1, cnt stays 0.
- HP_BURST = 4, both queues continuously valid, rdy_i = 1 → output pattern HP, HP, HP, HP, NP repeating. forced_o pulses in the cycle after each NP load.
- Only NP valid, words 0x0_0000_00A0..0x0_0000_00A3 → four outputs, each one cycle after its np_rdy. forced_o = 0.
- Output stalled with rdy_i = 0 for 5 cycles, both inputs valid → data_out and vld_o stable, hp_rdy = np_rdy = 0, cnt unchanged. Releasing rdy_i resumes with no word lost or duplicated.
- HP_BURST = 1, both valid → strict HP/NP alternation.
- rst asserted mid-stream with vld_o = 1 → vld_o, data_out, cnt and forced_o read 0 before the next clock edge. First grant after release is HP if hp_vld = 1.
